// File: rtl/pipeline_hazard_ctrl.sv
// Hazard/stall controller: load-use bubbles, multi-cycle MUL holds, taken-branch flushes.
// Latency: all controls are combinational from state, cnt and the current ID/EX inputs.
// Backpressure: stalls PC and IF/ID by dropping their write enables; ex_hold keeps EX iterating.
//
// Ports:
//   clock, reset (sync, active-low)
//   id_valid, id_rs1, id_rs2, id_uses_rs2               - instruction in ID
//   ex_opcode, ex_rd, ex_reg_write, ex_branch_taken     - instruction in EX
//   pc_write, if_id_write, if_id_flush, id_ex_write,
//   id_ex_bubble, ex_hold                               - pipeline register controls
//   stall_cycles                                        - perf counter
// Optional feature macro: HAZARD_PERF_EN builds the saturating stall_cycles counter;
// without it stall_cycles is tied to 0.
module pipeline_hazard_ctrl #(
  parameter int                OPC_W   = 4,
  parameter int                REG_AW  = 3,
  parameter logic [OPC_W-1:0]  OPC_LD  = 4'h8,
  parameter logic [OPC_W-1:0]  OPC_MUL = 4'h6,
  parameter int                MUL_LAT = 3
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              id_valid,
  input  logic [REG_AW-1:0] id_rs1,
  input  logic [REG_AW-1:0] id_rs2,
  input  logic              id_uses_rs2,
  input  logic [OPC_W-1:0]  ex_opcode,
  input  logic [REG_AW-1:0] ex_rd,
  input  logic              ex_reg_write,
  input  logic              ex_branch_taken,
  output logic              pc_write,
  output logic              if_id_write,
  output logic              if_id_flush,
  output logic              id_ex_write,
  output logic              id_ex_bubble,
  output logic              ex_hold,
  output logic [15:0]       stall_cycles
);

  typedef enum logic {RUN, MUL_WAIT} state_t;

  // The first hold cycle happens in RUN, so MUL_WAIT covers the remaining MUL_LAT-2 holds
  // plus the release cycle at cnt==0.
  localparam logic [3:0] CNT_INIT = 4'(MUL_LAT - 2);

  state_t     state;
  logic [3:0] cnt;

  logic ex_is_mul;
  logic load_use;

  assign ex_is_mul = (ex_opcode == OPC_MUL);

  // r0 is hardwired zero, so a load targeting it can never create a dependency.
  assign load_use = (ex_opcode == OPC_LD) && ex_reg_write && (ex_rd != '0) && id_valid &&
                    ((id_rs1 == ex_rd) || (id_uses_rs2 && (id_rs2 == ex_rd)));

  always_comb begin
    pc_write     = 1'b0;
    if_id_write  = 1'b0;
    if_id_flush  = 1'b0;
    id_ex_write  = 1'b0;
    id_ex_bubble = 1'b0;
    ex_hold      = 1'b0;
    if (reset) begin
      case (state)
        RUN: begin
          if (ex_is_mul) begin
            ex_hold = 1'b1;
          end else if (ex_branch_taken) begin
            pc_write     = 1'b1;
            if_id_write  = 1'b1;
            if_id_flush  = 1'b1;
            id_ex_write  = 1'b1;
            id_ex_bubble = 1'b1;
          end else if (load_use) begin
            id_ex_write  = 1'b1;
            id_ex_bubble = 1'b1;
          end else begin
            pc_write    = 1'b1;
            if_id_write = 1'b1;
            id_ex_write = 1'b1;
          end
        end
        MUL_WAIT: begin
          // Branch and load-use are ignored here: the MUL owns EX until it completes.
          if (cnt != 4'd0) begin
            ex_hold = 1'b1;
          end else begin
            pc_write    = 1'b1;
            if_id_write = 1'b1;
            id_ex_write = 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clock) begin
    if (!reset) begin
      state <= RUN;
      cnt   <= 4'd0;
    end else begin
      case (state)
        RUN: begin
          if (ex_is_mul) begin
            state <= MUL_WAIT;
            cnt   <= CNT_INIT;
          end
        end
        MUL_WAIT: begin
          if (cnt != 4'd0) begin
            cnt <= cnt - 4'd1;
          end else begin
            state <= RUN;
          end
        end
        default: begin
          state <= RUN;
          cnt   <= 4'd0;
        end
      endcase
    end
  end

`ifdef HAZARD_PERF_EN
  logic [15:0] perf_cnt;

  always_ff @(posedge clock) begin
    if (!reset) begin
      perf_cnt <= 16'd0;
    end else if (!pc_write && (perf_cnt != 16'hFFFF)) begin
      perf_cnt <= perf_cnt + 16'd1;
    end
  end

  // Gated so the output reads 0 throughout reset, not only after the clearing edge.
  assign stall_cycles = reset ? perf_cnt : 16'd0;
`else
  assign stall_cycles = 16'd0;
`endif

endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// Directed bench for pipeline_hazard_ctrl with hand-computed control vectors.
// Vector order: {pc_write, if_id_write, if_id_flush, id_ex_write, id_ex_bubble, ex_hold}.
module tb_pipeline_hazard_ctrl;

  logic        clock;
  logic        reset;
  logic        id_valid;
  logic [2:0]  id_rs1;
  logic [2:0]  id_rs2;
  logic        id_uses_rs2;
  logic [3:0]  ex_opcode;
  logic [2:0]  ex_rd;
  logic        ex_reg_write;
  logic        ex_branch_taken;
  logic        pc_write;
  logic        if_id_write;
  logic        if_id_flush;
  logic        id_ex_write;
  logic        id_ex_bubble;
  logic        ex_hold;
  logic [15:0] stall_cycles;

  int checks = 0;
  int errors = 0;
  int exp_stall = 0;

  localparam logic [5:0] ZERO = 6'b000000;
  localparam logic [5:0] NORM = 6'b110100;
  localparam logic [5:0] MULH = 6'b000001;
  localparam logic [5:0] BR   = 6'b111110;
  localparam logic [5:0] LU   = 6'b000110;

  localparam logic [3:0] ADD = 4'h1;
  localparam logic [3:0] LD  = 4'h8;
  localparam logic [3:0] MUL = 4'h6;
  localparam logic [3:0] NOP = 4'h0;

  pipeline_hazard_ctrl #(
    .OPC_W(4), .REG_AW(3), .OPC_LD(4'h8), .OPC_MUL(4'h6), .MUL_LAT(3)
  ) dut (
    .clock(clock),
    .reset(reset),
    .id_valid(id_valid),
    .id_rs1(id_rs1),
    .id_rs2(id_rs2),
    .id_uses_rs2(id_uses_rs2),
    .ex_opcode(ex_opcode),
    .ex_rd(ex_rd),
    .ex_reg_write(ex_reg_write),
    .ex_branch_taken(ex_branch_taken),
    .pc_write(pc_write),
    .if_id_write(if_id_write),
    .if_id_flush(if_id_flush),
    .id_ex_write(id_ex_write),
    .id_ex_bubble(id_ex_bubble),
    .ex_hold(ex_hold),
    .stall_cycles(stall_cycles)
  );

  initial begin
    clock = 1'b0;
    forever #5 clock = ~clock;
  end

  task automatic check(input string tag, input logic [15:0] got, input logic [15:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Apply one cycle of inputs at the falling edge, check the combinational controls
  // mid-cycle, then account for this cycle in the expected stall count.
  task automatic step(input string tag, input logic [5:0] exp,
                      input logic rst, input logic v, input logic [2:0] rs1,
                      input logic [2:0] rs2, input logic u2, input logic [3:0] opc,
                      input logic [2:0] rd, input logic rw, input logic bt);
    logic [15:0] exp_sc;
    @(negedge clock);
    reset           = rst;
    id_valid        = v;
    id_rs1          = rs1;
    id_rs2          = rs2;
    id_uses_rs2     = u2;
    ex_opcode       = opc;
    ex_rd           = rd;
    ex_reg_write    = rw;
    ex_branch_taken = bt;
    #2;
    check(tag, {10'd0, pc_write, if_id_write, if_id_flush, id_ex_write, id_ex_bubble, ex_hold},
          {10'd0, exp});
`ifdef HAZARD_PERF_EN
    exp_sc = rst ? 16'(exp_stall) : 16'd0;
`else
    exp_sc = 16'd0;
`endif
    check({tag, "_stall"}, stall_cycles, exp_sc);
    if (!rst) exp_stall = 0;
    else if (!exp[5]) exp_stall++;
  endtask

  initial begin
    reset = 1'b0; id_valid = 1'b0; id_rs1 = '0; id_rs2 = '0; id_uses_rs2 = 1'b0;
    ex_opcode = '0; ex_rd = '0; ex_reg_write = 1'b0; ex_branch_taken = 1'b0;

    //    tag             exp   rst v rs1  rs2  u2 opc  rd   rw bt
    step("reset0",        ZERO, 0, 1, 3'd3, 3'd0, 0, LD,  3'd3, 1, 0);
    step("reset1",        ZERO, 0, 0, 3'd0, 3'd0, 0, MUL, 3'd0, 0, 1);
    step("run_norm",      NORM, 1, 1, 3'd1, 3'd2, 1, ADD, 3'd4, 1, 0);
    step("lu_rs1",        LU,   1, 1, 3'd3, 3'd0, 0, LD,  3'd3, 1, 0);
    step("lu_after",      NORM, 1, 1, 3'd3, 3'd0, 0, NOP, 3'd0, 0, 0);
    step("lu_r0",         NORM, 1, 1, 3'd0, 3'd0, 0, LD,  3'd0, 1, 0);
    step("lu_rs2_unused", NORM, 1, 1, 3'd5, 3'd2, 0, LD,  3'd2, 1, 0);
    step("lu_rs2_used",   LU,   1, 1, 3'd5, 3'd2, 1, LD,  3'd2, 1, 0);
    step("lu_id_invalid", NORM, 1, 0, 3'd3, 3'd0, 0, LD,  3'd3, 1, 0);
    step("lu_no_wr",      NORM, 1, 1, 3'd3, 3'd0, 0, LD,  3'd3, 0, 0);
    step("mul_h1",        MULH, 1, 1, 3'd1, 3'd1, 1, MUL, 3'd1, 1, 0);
    step("mul_h2_ign",    MULH, 1, 1, 3'd3, 3'd0, 0, MUL, 3'd3, 1, 1);
    step("mul_rel",       NORM, 1, 1, 3'd1, 3'd1, 1, MUL, 3'd1, 1, 0);
    step("mul2_h1",       MULH, 1, 1, 3'd2, 3'd2, 1, MUL, 3'd2, 1, 0);
    step("mul2_h2",       MULH, 1, 1, 3'd2, 3'd2, 1, MUL, 3'd2, 1, 0);
    step("mul2_rel",      NORM, 1, 1, 3'd2, 3'd2, 1, MUL, 3'd2, 1, 0);
    step("post_mul",      NORM, 1, 1, 3'd1, 3'd2, 1, ADD, 3'd4, 1, 0);
    step("br_over_lu",    BR,   1, 1, 3'd3, 3'd0, 0, LD,  3'd3, 1, 1);
    step("br_after",      NORM, 1, 1, 3'd3, 3'd0, 0, NOP, 3'd0, 0, 0);
    step("rst_mul_h1",    MULH, 1, 1, 3'd1, 3'd1, 1, MUL, 3'd1, 1, 0);
    step("rst_mid_mul",   ZERO, 0, 1, 3'd1, 3'd1, 1, MUL, 3'd1, 1, 0);
    step("rst_release",   NORM, 1, 1, 3'd1, 3'd2, 1, ADD, 3'd4, 1, 0);
    step("mul_over_br",   MULH, 1, 1, 3'd3, 3'd0, 0, MUL, 3'd3, 1, 1);
    step("mul_over_br2",  MULH, 1, 1, 3'd3, 3'd0, 0, MUL, 3'd3, 1, 0);
    step("mul_over_rel",  NORM, 1, 1, 3'd3, 3'd0, 0, MUL, 3'd3, 1, 0);
    step("final_norm",    NORM, 1, 1, 3'd3, 3'd0, 0, ADD, 3'd3, 1, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
